int_issue_queue: RTL and testbench

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue.sv | 149 ++++++++++++++
 tb/tb_int_issue_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Four-entry integer issue queue with CDB wakeup and dispatch bypass.
// Optional macro IQ_AGE_PRIORITY_EN selects the oldest ready entry.
module int_issue_queue (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Dispatch_En,
  input  logic [2:0]  Dispatch_Opcode,
  input  logic [4:0]  Dispatch_RdTag,
  input  logic [4:0]  Dispatch_RsTag,
  input  logic [4:0]  Dispatch_RtTag,
  input  logic [31:0] Dispatch_RsData,
  input  logic [31:0] Dispatch_RtData,
  input  logic        Dispatch_RsValid,
  input  logic        Dispatch_RtValid,
  input  logic [4:0]  CDB_Tag,
  input  logic [31:0] CDB_Data,
  input  logic        CDB_Valid,
  output logic        Ready,
  input  logic        Issue,
  output logic [2:0]  Issue_Opcode,
  output logic [4:0]  Issue_RdTag,
  output logic [31:0] Issue_RsData,
  output logic [31:0] Issue_RtData,
  output logic        Queue_Full,
  output logic [2:0]  Queue_Count
);
  localparam int N = 4;

  logic [N-1:0] r_v;
  logic [N-1:0] r_rsv;
  logic [N-1:0] r_rtv;
  logic [2:0]   r_op  [N];
  logic [4:0]   r_rd  [N];
  logic [4:0]   r_rst [N];
  logic [4:0]   r_rtt [N];
  logic [31:0]  r_rsd [N];
  logic [31:0]  r_rtd [N];
  logic [2:0]   r_count;

  logic [N-1:0] w_rdy;
  logic [1:0]   w_sel;
  logic [1:0]   w_free;
  logic         w_iss;
  logic         w_disp;
  logic         w_rs_byp;
  logic         w_rt_byp;

  assign w_rdy       = r_v & r_rsv & r_rtv;
  assign Ready       = |w_rdy;
  assign Queue_Full  = (r_count == 3'd4);
  assign Queue_Count = r_count;
  assign w_iss       = Issue & Ready;
  assign w_disp      = Dispatch_En & ~Queue_Full;
  assign w_rs_byp    = CDB_Valid & (Dispatch_RsTag == CDB_Tag);
  assign w_rt_byp    = CDB_Valid & (Dispatch_RtTag == CDB_Tag);

  // Lowest-index free slot receives the next dispatch
  always_comb begin
    w_free = 2'd0;
    for (int i = N - 1; i >= 0; i--)
      if (!r_v[i]) w_free = 2'(i);
  end

`ifdef IQ_AGE_PRIORITY_EN
  // r_older[i][j] set means entry i was dispatched before entry j
  logic [N-1:0] r_older [N];

  // Pick the ready entry that no other ready entry is older than
  always_comb begin
    logic [N-1:0] w_col;
    w_sel = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = 0; j < N; j++)
        w_col[j] = r_older[j][i];
      if (w_rdy[i] && !(|(w_rdy & w_col)))
        w_sel = 2'(i);
    end
  end

  // Age matrix: a new entry is younger than all, an issued one drops out
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < N; i++) r_older[i] <= '0;
    end else begin
      if (w_iss) r_older[w_sel] <= '0;
      if (w_disp) begin
        for (int j = 0; j < N; j++)
          if (j != int'(w_free)) r_older[j][w_free] <= 1'b1;
        r_older[w_free] <= '0;
      end
    end
  end
`else
  // Lowest-index ready entry wins
  always_comb begin
    w_sel = 2'd0;
    for (int i = N - 1; i >= 0; i--)
      if (w_rdy[i]) w_sel = 2'(i);
  end
`endif

  // Selected entry is shown only while something is ready
  always_comb begin
    Issue_Opcode = '0;
    Issue_RdTag  = '0;
    Issue_RsData = '0;
    Issue_RtData = '0;
    if (Ready) begin
      Issue_Opcode = r_op[w_sel];
      Issue_RdTag  = r_rd[w_sel];
      Issue_RsData = r_rsd[w_sel];
      Issue_RtData = r_rtd[w_sel];
    end
  end

  // Wakeup, issue and dispatch all commit on one edge
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_v     <= '0;
      r_count <= 3'd0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_v[i] && CDB_Valid && !r_rsv[i] && r_rst[i] == CDB_Tag) begin
          r_rsd[i] <= CDB_Data;
          r_rsv[i] <= 1'b1;
        end
        if (r_v[i] && CDB_Valid && !r_rtv[i] && r_rtt[i] == CDB_Tag) begin
          r_rtd[i] <= CDB_Data;
          r_rtv[i] <= 1'b1;
        end
      end
      if (w_iss) r_v[w_sel] <= 1'b0;
      if (w_disp) begin
        r_v[w_free]   <= 1'b1;
        r_op[w_free]  <= Dispatch_Opcode;
        r_rd[w_free]  <= Dispatch_RdTag;
        r_rst[w_free] <= Dispatch_RsTag;
        r_rtt[w_free] <= Dispatch_RtTag;
        r_rsv[w_free] <= Dispatch_RsValid | w_rs_byp;
        r_rtv[w_free] <= Dispatch_RtValid | w_rt_byp;
        r_rsd[w_free] <= (!Dispatch_RsValid && w_rs_byp) ?
                         CDB_Data : Dispatch_RsData;
        r_rtd[w_free] <= (!Dispatch_RtValid && w_rt_byp) ?
                         CDB_Data : Dispatch_RtData;
      end
      r_count <= r_count + {2'b0, w_disp} - {2'b0, w_iss};
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Testbench for int_issue_queue: directed scenarios then random traffic
// checked against a slot/sequence-number reference model.
module tb_int_issue_queue;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        Dispatch_En;
  logic [2:0]  Dispatch_Opcode;
  logic [4:0]  Dispatch_RdTag;
  logic [4:0]  Dispatch_RsTag;
  logic [4:0]  Dispatch_RtTag;
  logic [31:0] Dispatch_RsData;
  logic [31:0] Dispatch_RtData;
  logic        Dispatch_RsValid;
  logic        Dispatch_RtValid;
  logic [4:0]  CDB_Tag;
  logic [31:0] CDB_Data;
  logic        CDB_Valid;
  logic        Ready;
  logic        Issue;
  logic [2:0]  Issue_Opcode;
  logic [4:0]  Issue_RdTag;
  logic [31:0] Issue_RsData;
  logic [31:0] Issue_RtData;
  logic        Queue_Full;
  logic [2:0]  Queue_Count;

  int total = 0;
  int bad = 0;

  int_issue_queue dut (
    .Clk(Clk), .Rst(Rst),
    .Dispatch_En(Dispatch_En),
    .Dispatch_Opcode(Dispatch_Opcode),
    .Dispatch_RdTag(Dispatch_RdTag),
    .Dispatch_RsTag(Dispatch_RsTag),
    .Dispatch_RtTag(Dispatch_RtTag),
    .Dispatch_RsData(Dispatch_RsData),
    .Dispatch_RtData(Dispatch_RtData),
    .Dispatch_RsValid(Dispatch_RsValid),
    .Dispatch_RtValid(Dispatch_RtValid),
    .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data),
    .CDB_Valid(CDB_Valid),
    .Ready(Ready), .Issue(Issue),
    .Issue_Opcode(Issue_Opcode),
    .Issue_RdTag(Issue_RdTag),
    .Issue_RsData(Issue_RsData),
    .Issue_RtData(Issue_RtData),
    .Queue_Full(Queue_Full),
    .Queue_Count(Queue_Count)
  );

  always #5 Clk = ~Clk;

  // Reference model: slots plus a global dispatch sequence number
  bit          m_v   [4];
  bit [2:0]    m_op  [4];
  bit [4:0]    m_rd  [4];
  bit [4:0]    m_rst [4];
  bit [4:0]    m_rtt [4];
  bit [31:0]   m_rsd [4];
  bit [31:0]   m_rtd [4];
  bit          m_rsv [4];
  bit          m_rtv [4];
  int          m_seq [4];
  int          seqn = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 4; i++) if (m_v[i]) c++;
    return c;
  endfunction

  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_v[i] && m_rsv[i] && m_rtv[i]) begin
`ifdef IQ_AGE_PRIORITY_EN
        if (s < 0 || m_seq[i] < m_seq[s]) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  task automatic check_outputs();
    int s = m_sel();
    int c = m_cnt();
    chk("ready", 32'(Ready), 32'(s >= 0));
    chk("count", 32'(Queue_Count), 32'(c));
    chk("full", 32'(Queue_Full), 32'(c == 4));
    if (s >= 0) begin
      chk("iss_op", 32'(Issue_Opcode), 32'(m_op[s]));
      chk("iss_rd", 32'(Issue_RdTag), 32'(m_rd[s]));
      chk("iss_rs", Issue_RsData, m_rsd[s]);
      chk("iss_rt", Issue_RtData, m_rtd[s]);
    end else begin
      chk("iss_zero_tag", 32'({Issue_Opcode, Issue_RdTag}), 32'd0);
      chk("iss_zero_rs", Issue_RsData, 32'd0);
      chk("iss_zero_rt", Issue_RtData, 32'd0);
    end
  endtask

  task automatic model_edge();
    int s = m_sel();
    int c = m_cnt();
    int d = -1;
    if (!Rst) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
      return;
    end
    if (Dispatch_En && c < 4)
      for (int i = 3; i >= 0; i--) if (!m_v[i]) d = i;
    for (int i = 0; i < 4; i++) begin
      if (m_v[i] && CDB_Valid && !m_rsv[i] && m_rst[i] == CDB_Tag) begin
        m_rsv[i] = 1; m_rsd[i] = CDB_Data;
      end
      if (m_v[i] && CDB_Valid && !m_rtv[i] && m_rtt[i] == CDB_Tag) begin
        m_rtv[i] = 1; m_rtd[i] = CDB_Data;
      end
    end
    if (Issue && s >= 0) m_v[s] = 0;
    if (d >= 0) begin
      m_v[d] = 1;
      m_op[d] = Dispatch_Opcode;
      m_rd[d] = Dispatch_RdTag;
      m_rst[d] = Dispatch_RsTag;
      m_rtt[d] = Dispatch_RtTag;
      m_rsv[d] = 1; m_rtv[d] = 1;
      m_rsd[d] = Dispatch_RsData;
      m_rtd[d] = Dispatch_RtData;
      if (!Dispatch_RsValid) begin
        if (CDB_Valid && CDB_Tag == Dispatch_RsTag) m_rsd[d] = CDB_Data;
        else m_rsv[d] = 0;
      end
      if (!Dispatch_RtValid) begin
        if (CDB_Valid && CDB_Tag == Dispatch_RtTag) m_rtd[d] = CDB_Data;
        else m_rtv[d] = 0;
      end
      m_seq[d] = seqn;
      seqn++;
    end
  endtask

  task automatic cyc(bit do_chk = 1);
    if (do_chk) check_outputs();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    Dispatch_En = 0; Dispatch_Opcode = 0; Dispatch_RdTag = 0;
    Dispatch_RsTag = 0; Dispatch_RtTag = 0;
    Dispatch_RsData = 0; Dispatch_RtData = 0;
    Dispatch_RsValid = 0; Dispatch_RtValid = 0;
    CDB_Tag = 0; CDB_Data = 0; CDB_Valid = 0; Issue = 0;
  endtask

  task automatic disp(bit [2:0] op, bit [4:0] rd,
                      bit [4:0] rst, bit [31:0] rsd, bit rsv,
                      bit [4:0] rtt, bit [31:0] rtd, bit rtv);
    Dispatch_En = 1; Dispatch_Opcode = op; Dispatch_RdTag = rd;
    Dispatch_RsTag = rst; Dispatch_RsData = rsd; Dispatch_RsValid = rsv;
    Dispatch_RtTag = rtt; Dispatch_RtData = rtd; Dispatch_RtValid = rtv;
  endtask

  task automatic do_reset();
    idle(); Rst = 0;
    cyc();
    Rst = 1;
  endtask

  initial begin
    idle(); Rst = 0;
    cyc(0);
    Rst = 1;
    chk("rst_ready", 32'(Ready), 32'd0);
    chk("rst_count", 32'(Queue_Count), 32'd0);
    check_outputs();

    // Basic dispatch then issue
    disp(3'd3, 5'd5, 5'd1, 32'h10, 1, 5'd2, 32'h20, 1);
    cyc(); idle();
    chk("b_ready", 32'(Ready), 32'd1);
    chk("b_rs", Issue_RsData, 32'h10);
    Issue = 1; cyc(); idle();
    chk("b_cnt0", 32'(Queue_Count), 32'd0);
    chk("b_rdy0", 32'(Ready), 32'd0);

    // CDB wakeup arrives one cycle after dispatch
    disp(3'd1, 5'd6, 5'd7, 32'h0, 0, 5'd3, 32'h33, 1);
    cyc(); idle();
    CDB_Tag = 5'd7; CDB_Data = 32'hDEADBEEF; CDB_Valid = 1;
    chk("wk_rdy_same", 32'(Ready), 32'd0);
    cyc(); idle();
    chk("wk_rdy_next", 32'(Ready), 32'd1);
    chk("wk_rs", Issue_RsData, 32'hDEADBEEF);
    Issue = 1; cyc(); idle();

    // Dispatch bypass from the CDB
    disp(3'd2, 5'd8, 5'd4, 32'h44, 1, 5'd9, 32'h0, 0);
    CDB_Tag = 5'd9; CDB_Data = 32'h55; CDB_Valid = 1;
    cyc(); idle();
    chk("byp_rdy", 32'(Ready), 32'd1);
    chk("byp_rt", Issue_RtData, 32'h55);
    Issue = 1; cyc(); idle();

    // Fill to four, fifth dropped, issue+dispatch while full
    for (int k = 0; k < 5; k++) begin
      disp(3'(k), 5'(k + 10), 5'd0, 32'(k), 1, 5'd0, 32'(k * 2), 1);
      cyc();
    end
    idle();
    chk("full_flag", 32'(Queue_Full), 32'd1);
    chk("full_cnt", 32'(Queue_Count), 32'd4);
    disp(3'd7, 5'd31, 5'd0, 32'h77, 1, 5'd0, 32'h78, 1);
    Issue = 1; cyc(); idle();
    chk("full_iss_cnt", 32'(Queue_Count), 32'd3);
    cyc();

    // Selection order after a slot is recycled
    do_reset();
    disp(3'd1, 5'd1, 5'd0, 32'hA, 1, 5'd0, 32'hA, 1); cyc();
    disp(3'd2, 5'd2, 5'd0, 32'hB, 1, 5'd0, 32'hB, 1); cyc();
    idle(); Issue = 1; cyc(); idle();
    disp(3'd3, 5'd3, 5'd0, 32'hC, 1, 5'd0, 32'hC, 1); cyc(); idle();
`ifdef IQ_AGE_PRIORITY_EN
    chk("order_rd", 32'(Issue_RdTag), 32'd2);
`else
    chk("order_rd", 32'(Issue_RdTag), 32'd3);
`endif
    Issue = 1; cyc(); cyc(); idle(); cyc();

    // Reset beats a pending wakeup
    do_reset();
    for (int k = 0; k < 3; k++) begin
      disp(3'd1, 5'(k), 5'd4, 32'h0, 0, 5'd0, 32'h1, 1);
      cyc();
    end
    idle();
    chk("pre_rst_cnt", 32'(Queue_Count), 32'd3);
    Rst = 0; CDB_Tag = 5'd4; CDB_Data = 32'h99; CDB_Valid = 1;
    cyc(); idle(); Rst = 1;
    chk("rst_wk_cnt", 32'(Queue_Count), 32'd0);
    chk("rst_wk_rdy", 32'(Ready), 32'd0);
    disp(3'd5, 5'd20, 5'd0, 32'h5, 1, 5'd0, 32'h6, 1);
    cyc(); idle();
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      Rst = ($urandom_range(0, 60) != 0);
      Dispatch_En = ($urandom_range(0, 9) < 6);
      Dispatch_Opcode = 3'($urandom);
      Dispatch_RdTag = 5'($urandom);
      Dispatch_RsTag = 5'($urandom_range(0, 7));
      Dispatch_RtTag = 5'($urandom_range(0, 7));
      Dispatch_RsData = $urandom;
      Dispatch_RtData = $urandom;
      Dispatch_RsValid = 1'($urandom);
      Dispatch_RtValid = 1'($urandom);
      CDB_Valid = 1'($urandom);
      CDB_Tag = 5'($urandom_range(0, 7));
      CDB_Data = $urandom;
      Issue = ($urandom_range(0, 9) < 4);
      cyc();
    end
    idle(); Rst = 1;
    cyc();
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
